// File: rtl/serial_word_tx.sv
// serial_word_tx: accepts a parallel word and shifts it out MSB first over a
// valid/ready serial link, followed by a fixed number of idle gap cycles.
// Tracks whether the last accepted word matched SIGNATURE and counts frames.
module serial_word_tx #(
    parameter int              WIDTH     = 24,
    parameter logic [WIDTH-1:0] SIGNATURE = WIDTH'(24'hC0FFEE),
    parameter int              GAP       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_first,
    output logic             ser_last,
    output logic             sig_match,
    output logic [15:0]      frame_count
);

    localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
    // Gap counter is loaded with GAP-1 so the GAP state lasts exactly GAP cycles.
    localparam logic [3:0]       GAP_LAST = 4'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shift;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_gap_cnt;
    logic             r_sig_match;
    logic [15:0]      r_frame_count;

    logic w_accept;
    logic w_xfer;
    logic w_last_xfer;

    // Handshake qualifiers; input is only looked at in IDLE, so nothing is buffered.
    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_xfer      = ser_ready && (r_state == S_SHIFT);
    assign w_last_xfer = w_xfer && (r_idx == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_last_xfer) w_next = (GAP > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (r_gap_cnt == 4'd0) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Shift register, bit index, gap counter, match flag and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift       <= '0;
            r_idx         <= '0;
            r_gap_cnt     <= 4'd0;
            r_sig_match   <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            if (w_accept) begin
                r_shift     <= in_data;
                r_idx       <= IDX_TOP;
                r_sig_match <= (in_data == SIGNATURE);
            end else if (w_xfer) begin
                r_shift <= r_shift << 1;
                if (r_idx != '0) r_idx <= r_idx - IDX_W'(1);
                if (w_last_xfer) begin
                    r_frame_count <= r_frame_count + 16'd1;
                    r_gap_cnt     <= GAP_LAST;
                end
            end else if (r_state == S_GAP && r_gap_cnt != 4'd0) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end
        end
    end

    // Outputs are decoded from state so reset forces them without a clock.
    assign in_ready    = (r_state == S_IDLE);
    assign ser_valid   = (r_state == S_SHIFT);
    assign ser_data    = ser_valid && r_shift[WIDTH-1];
    assign ser_first   = ser_valid && (r_idx == IDX_TOP);
    assign ser_last    = ser_valid && (r_idx == '0);
    assign sig_match   = r_sig_match;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: default build plus a GAP=0, 8-bit build.
module tb_serial_word_tx;

    localparam logic [23:0] SIG = 24'hC0FFEE;

    logic        clk;
    logic        rst_n;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        ser_data;
    logic        ser_valid;
    logic        ser_ready;
    logic        ser_first;
    logic        ser_last;
    logic        sig_match;
    logic [15:0] frame_count;

    logic [7:0]  g_data;
    logic        g_valid;
    logic        g_in_ready;
    logic        g_ser_data;
    logic        g_ser_valid;
    logic        g_ser_ready;
    logic        g_ser_first;
    logic        g_ser_last;
    logic        g_sig_match;
    logic [15:0] g_frame_count;

    int n_pass  = 0;
    int n_total = 0;

    serial_word_tx dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
        .ser_first(ser_first), .ser_last(ser_last),
        .sig_match(sig_match), .frame_count(frame_count)
    );

    serial_word_tx #(.WIDTH(8), .SIGNATURE(8'h3C), .GAP(0)) u_g0 (
        .clk(clk), .rst_n(rst_n),
        .in_data(g_data), .in_valid(g_valid), .in_ready(g_in_ready),
        .ser_data(g_ser_data), .ser_valid(g_ser_valid), .ser_ready(g_ser_ready),
        .ser_first(g_ser_first), .ser_last(g_ser_last),
        .sig_match(g_sig_match), .frame_count(g_frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full frame on the default build, entered with the DUT idle.
    task automatic run_frame(input logic [23:0] w, input int stall_idx, input int stall_len,
                             input bit hold, input logic [15:0] exp_fc);
        in_data   = w;
        in_valid  = 1'b1;
        ser_ready = 1'b1;
        chk("rdy_before_accept", {31'd0, in_ready}, 32'd1);
        step();
        if (hold) in_data = ~w;
        else      in_valid = 1'b0;
        chk("sig_match", {31'd0, sig_match}, {31'd0, (w == SIG)});
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        for (int i = 23; i >= 0; i--) begin
            if (i == stall_idx) begin
                ser_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    chk("stall_hold", {28'd0, ser_valid, ser_data, ser_first, ser_last},
                        {28'd0, 1'b1, w[i], (i == 23), (i == 0)});
                end
                ser_ready = 1'b1;
            end
            chk("bit", {28'd0, ser_valid, ser_data, ser_first, ser_last},
                {28'd0, 1'b1, w[i], (i == 23), (i == 0)});
            step();
        end
        ser_ready = 1'b0;
        for (int g = 0; g < 2; g++) begin
            chk("gap", {30'd0, in_ready, ser_valid}, 32'd0);
            step();
        end
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        chk("rdy_after_frame", {31'd0, in_ready}, 32'd1);
        chk("frame_count", {16'd0, frame_count}, {16'd0, exp_fc});
    endtask

    initial begin
        rst_n       = 1'b0;
        in_data     = 24'd0;
        in_valid    = 1'b0;
        ser_ready   = 1'b0;
        g_data      = 8'd0;
        g_valid     = 1'b0;
        g_ser_ready = 1'b1;

        #2;
        chk("reset_outputs", {26'd0, in_ready, ser_valid, ser_data, ser_first, ser_last, sig_match},
            32'b100000);
        chk("reset_fc", {16'd0, frame_count}, 32'd0);
        chk("reset_g0", {30'd0, g_in_ready, g_ser_valid}, 32'b10);
        step();
        step();
        rst_n = 1'b1;

        // Abort: async reset between edges while bit 7 is on the line.
        in_data   = SIG;
        in_valid  = 1'b1;
        ser_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 23; i > 7; i--) step();
        chk("abort_pre_bit7", {29'd0, ser_valid, ser_data, sig_match}, 32'b111);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {26'd0, in_ready, ser_valid, ser_data, ser_first, ser_last, sig_match},
            32'b100000);
        chk("abort_fc", {16'd0, frame_count}, 32'd0);
        step();
        rst_n = 1'b1;
        chk("abort_fc_after", {16'd0, frame_count}, 32'd0);

        // Signature word with in_valid held throughout; second word is not a match.
        run_frame(SIG, -1, 0, 1'b1, 16'd1);
        run_frame(24'h123456, -1, 0, 1'b0, 16'd2);
        // Backpressure for five cycles while bit 10 is presented.
        run_frame(24'hA5A5A5, 10, 5, 1'b0, 16'd3);

        // Counter wrap.
        #3;
        force dut.r_frame_count = 16'hFFFF;
        #1;
        release dut.r_frame_count;
        chk("fc_preload", {16'd0, frame_count}, 32'h0000FFFF);
        step();
        run_frame(24'h00F00F, -1, 0, 1'b0, 16'd0);

        // GAP=0 build, back-to-back words with in_valid held.
        g_data  = 8'hA5;
        g_valid = 1'b1;
        step();
        for (int i = 7; i >= 0; i--) begin
            chk("g0_bit_w0", {28'd0, g_ser_valid, g_ser_data, g_ser_first, g_ser_last},
                {28'd0, 1'b1, g_data[i], (i == 7), (i == 0)});
            step();
        end
        chk("g0_ready_after_last", {30'd0, g_in_ready, g_ser_valid}, 32'b10);
        chk("g0_fc1", {16'd0, g_frame_count}, 32'd1);
        chk("g0_sig_w0", {31'd0, g_sig_match}, 32'd0);
        g_data = 8'h3C;
        step();
        for (int i = 7; i >= 0; i--) begin
            chk("g0_bit_w1", {28'd0, g_ser_valid, g_ser_data, g_ser_first, g_ser_last},
                {28'd0, 1'b1, g_data[i], (i == 7), (i == 0)});
            step();
        end
        g_valid = 1'b0;
        chk("g0_sig_w1", {31'd0, g_sig_match}, 32'd1);
        chk("g0_fc2", {16'd0, g_frame_count}, 32'd2);
        chk("g0_idle", {30'd0, g_in_ready, g_ser_valid}, 32'b10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
